// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Package : i2s_pkg
// Brief   : Shared I2S types: frame formats, slot-length floor, shadow config.
// Rev     : 1.0 - initial release
// ============================================================================
package i2s_pkg;

  // The shadow-config struct is sized by these; top-level parameters default to them.
  localparam int I2S_DIV_WIDTH  = 8;
  localparam int I2S_SLOT_MAX   = 8;
  localparam int I2S_SLOT_IDX_W = $clog2(I2S_SLOT_MAX);
  localparam int I2S_BIT_IDX_W  = 5;

  localparam logic [I2S_BIT_IDX_W-1:0] I2S_SLOT_LEN_MIN = 5'd7;

  typedef enum logic [1:0] {
    I2S_MODE_STD = 2'd0,
    I2S_MODE_LJ  = 2'd1,
    I2S_MODE_TDM = 2'd2
  } i2s_mode_e;

  typedef struct packed {
    logic [I2S_DIV_WIDTH-1:0]  div;
    i2s_mode_e                 mode;
    logic [I2S_BIT_IDX_W-1:0]  slot_len;
    logic [I2S_SLOT_IDX_W-1:0] slot_num;
  } i2s_cfg_t;

  // Encoding 3 is reserved and behaves as standard I2S.
  function automatic i2s_mode_e i2s_decode_mode(input logic [1:0] mode);
    return (mode == 2'd3) ? I2S_MODE_STD : i2s_mode_e'(mode);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_sck_div.sv
`default_nettype none
// ============================================================================
// Module  : i2s_sck_div
// Brief   : SCK half-period divider; emits sample/drive pulses on SCK toggles.
// Rev     : 1.0 - initial release
// ============================================================================
module i2s_sck_div #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 run_i,
  input  logic                 pol_i,
  input  logic [DIV_WIDTH-1:0] reload_i,
  output logic                 sck_o,
  output logic                 sample_stb_o,
  output logic                 drive_stb_o
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 r_sck;
  logic                 w_zero;

  assign w_zero       = run_i && (r_cnt == '0);
  assign sample_stb_o = w_zero && (r_sck == pol_i);
  assign drive_stb_o  = w_zero && (r_sck != pol_i);
  assign sck_o        = r_sck;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (!run_i) begin
      r_cnt <= reload_i;
      r_sck <= pol_i;
    end else if (w_zero) begin
      r_cnt <= reload_i;
      r_sck <= ~r_sck;
    end else begin
      r_cnt <= r_cnt - DIV_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2s_tdm_clkgen.sv
`default_nettype none
// ============================================================================
// Module  : i2s_tdm_clkgen
// Brief   : I2S / left-justified / TDM bit and frame clock generator with
//           drive/sample strobes and slot/bit indices for the shifters.
// Options : I2S_CLKGEN_FRMCNT_EN adds the 16-bit frame counter frame_cnt_o.
// Rev     : 1.0 - initial release
// ============================================================================
module i2s_tdm_clkgen
  import i2s_pkg::*;
#(
  parameter int DIV_WIDTH  = I2S_DIV_WIDTH,
  parameter int SLOT_MAX   = I2S_SLOT_MAX,
  parameter int SLOT_IDX_W = $clog2(SLOT_MAX),
  parameter int BIT_IDX_W  = I2S_BIT_IDX_W
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic                  pol_i,
  input  logic [1:0]            mode_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic [BIT_IDX_W-1:0]  slot_len_i,
  input  logic [SLOT_IDX_W-1:0] slot_num_i,
  output logic                  sck_o,
  output logic                  ws_o,
  output logic                  tx_stb_o,
  output logic                  rx_stb_o,
  output logic                  frame_start_o,
  output logic [SLOT_IDX_W-1:0] slot_idx_o,
  output logic [BIT_IDX_W-1:0]  bit_idx_o
`ifdef I2S_CLKGEN_FRMCNT_EN
  ,
  output logic [15:0]           frame_cnt_o
`endif
);

  logic                  r_run;
  logic                  r_ws;
  logic [SLOT_IDX_W-1:0] r_slot;
  logic [BIT_IDX_W-1:0]  r_bit;
  i2s_cfg_t              r_cfg;

  i2s_cfg_t              w_new_cfg;
  i2s_cfg_t              w_cfg;
  logic                  w_start;
  logic                  w_run;
  logic                  w_drive;
  logic                  w_sample;
  logic                  w_last_bit;
  logic                  w_wrap;
  logic                  w_ws_nxt;
  logic [SLOT_IDX_W-1:0] w_slot;
  logic [BIT_IDX_W-1:0]  w_bit;

  always_comb begin
    w_new_cfg.div      = div_i;
    w_new_cfg.mode     = i2s_decode_mode(mode_i);
    w_new_cfg.slot_len = (slot_len_i < I2S_SLOT_LEN_MIN) ? I2S_SLOT_LEN_MIN : slot_len_i;
    w_new_cfg.slot_num = (w_new_cfg.mode == I2S_MODE_TDM) ? slot_num_i : SLOT_IDX_W'(1);
  end

  assign w_start    = en_i && !r_run;
  assign w_run      = en_i && r_run;
  assign w_last_bit = (r_bit == '0);
  assign w_wrap     = w_drive && w_last_bit && (r_slot == r_cfg.slot_num);
  // Fresh inputs apply from the first bit of a frame; otherwise the shadow copy.
  assign w_cfg      = (!w_run || w_wrap) ? w_new_cfg : r_cfg;

  i2s_sck_div #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_sck_div (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .run_i        (w_run),
    .pol_i        (pol_i),
    .reload_i     (w_cfg.div),
    .sck_o        (sck_o),
    .sample_stb_o (w_sample),
    .drive_stb_o  (w_drive)
  );

  // Indices of the bit being driven this cycle.
  always_comb begin
    w_slot = r_slot;
    w_bit  = r_bit;
    if (!w_run || w_wrap) begin
      w_slot = '0;
      w_bit  = w_new_cfg.slot_len;
    end else if (w_drive) begin
      if (w_last_bit) begin
        w_slot = r_slot + SLOT_IDX_W'(1);
        w_bit  = r_cfg.slot_len;
      end else begin
        w_bit  = r_bit - BIT_IDX_W'(1);
      end
    end
  end

  // Standard I2S always has two slots, so the next bit's slot parity flips on the LSB.
  always_comb begin
    case (w_cfg.mode)
      I2S_MODE_LJ:  w_ws_nxt = w_slot[0];
      I2S_MODE_TDM: w_ws_nxt = (w_slot == w_cfg.slot_num) && (w_bit == '0);
      default:      w_ws_nxt = w_slot[0] ^ (w_bit == '0);
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_run  <= 1'b0;
      r_ws   <= 1'b0;
      r_slot <= '0;
      r_bit  <= '0;
      r_cfg  <= '0;
    end else begin
      r_run <= en_i;
      if (!en_i) begin
        r_ws <= 1'b0;
      end else if (w_start || w_drive) begin
        r_ws <= w_ws_nxt;
      end
      if (!w_run || w_drive) begin
        r_slot <= w_slot;
        r_bit  <= w_bit;
      end
      if (!w_run || w_wrap) begin
        r_cfg <= w_new_cfg;
      end
    end
  end

  assign ws_o          = r_ws;
  assign tx_stb_o      = w_start || w_drive;
  assign rx_stb_o      = w_sample;
  assign frame_start_o = w_start || w_wrap;
  assign slot_idx_o    = w_slot;
  assign bit_idx_o     = w_bit;

`ifdef I2S_CLKGEN_FRMCNT_EN
  logic [15:0] r_frame_cnt;

  // The frame opened by enable itself is not counted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_frame_cnt <= '0;
    end else if (!en_i) begin
      r_frame_cnt <= '0;
    end else if (w_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt_o = r_frame_cnt;
`endif

endmodule
`default_nettype wire
